control_sequencer: RTL

- Hardwired control unit directly upstream of the datapath. It consumes the IR opcode and the CON FF result, and produces every datapath control strobe, so benches no longer drive strobes by hand.
- Moore FSM: fetch (T0–T2), then an opcode-specific execute sequence, then back to T0.
- Supports the full Phase-2/3 instruction set, plus halt/stop.

---
 rtl/control_sequencer.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, opcode-specific execute, back to T0.
// Define SINGLE_STEP_EN to add a Step input that parks the FSM in STEP_WAIT between instructions.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [4:0]  opcode,
  input  logic        con_ff,
  input  logic        Stop,
`ifdef SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        RAMin,
  output logic        IRin,
  output logic        Yin,
  output logic        Cout,
  output logic        CONin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        BAout,
  output logic        Rin,
  output logic        Rout,
  output logic        InPortOut,
  output logic        OutPortIn,
  output logic        InPortIn,
  output logic [15:0] REGin,
  output logic        Run,
  output logic [5:0]  state_dbg
);

  typedef enum logic [5:0] {
    ST_RST  = 6'd0,
    ST_T0   = 6'd1,
    ST_T1   = 6'd2,
    ST_T2   = 6'd3,
    ST_T3   = 6'd4,
    ST_T4   = 6'd5,
    ST_T5   = 6'd6,
    ST_T6   = 6'd7,
    ST_T7   = 6'd8,
`ifdef SINGLE_STEP_EN
    ST_STEP_WAIT = 6'd10,
`endif
    ST_HALT = 6'd9
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_ALUI, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } op_class_t;

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

  state_t     state_reg, state_next;
  op_class_t  class_reg, class_next;
  logic [2:0] wait_reg, wait_next;
  logic       con_reg, con_next;
  logic       last_step;
  logic       jal_pc_save;

  function automatic op_class_t decode_op(input logic [4:0] op);
    op_class_t c;
    c = C_NOP;
    if (op == 5'd0)       c = C_LD;
    else if (op == 5'd1)  c = C_LDI;
    else if (op == 5'd2)  c = C_ST;
    else if (op <= 5'd11) c = C_ALU;
    else if (op <= 5'd14) c = C_ALUI;
    else if (op <= 5'd16) c = C_MULDIV;
    else if (op <= 5'd18) c = C_UNARY;
    else if (op == 5'd19) c = C_BR;
    else if (op == 5'd20) c = C_JR;
    else if (op == 5'd21) c = C_JAL;
    else if (op == 5'd22) c = C_IN;
    else if (op == 5'd23) c = C_OUT;
    else if (op == 5'd24) c = C_MFHI;
    else if (op == 5'd25) c = C_MFLO;
    else if (op == 5'd27) c = C_HALT;
    return c;
  endfunction

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_reg <= ST_RST;
      class_reg <= C_NOP;
      wait_reg  <= 3'd0;
      con_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      class_reg <= class_next;
      wait_reg  <= wait_next;
      con_reg   <= con_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    class_next = class_reg;
    wait_next  = wait_reg;
    con_next   = con_reg;
    last_step  = 1'b0;
    case (state_reg)
      ST_RST: state_next = ST_T0;
      ST_T0: begin
        state_next = ST_T1;
        wait_next  = WAIT_LOAD;
      end
      ST_T1: begin
        if (wait_reg == 3'd0) state_next = ST_T2;
        else                  wait_next  = wait_reg - 3'd1;
      end
      ST_T2: begin
        state_next = ST_T3;
        class_next = decode_op(opcode);
      end
      ST_T3: begin
        case (class_reg)
          C_HALT: state_next = ST_HALT;
          C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP: last_step = 1'b1;
          default: state_next = ST_T4;
        endcase
      end
      ST_T4: begin
        case (class_reg)
          C_UNARY, C_JAL: last_step = 1'b1;
          default: state_next = ST_T5;
        endcase
      end
      ST_T5: begin
        case (class_reg)
          C_LD: begin
            state_next = ST_T6;
            wait_next  = WAIT_LOAD;
          end
          C_ST, C_MULDIV: state_next = ST_T6;
          C_BR: begin
            state_next = ST_T6;
            con_next   = con_ff;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_T6: begin
        case (class_reg)
          C_LD: begin
            if (wait_reg == 3'd0) state_next = ST_T7;
            else                  wait_next  = wait_reg - 3'd1;
          end
          C_ST: begin
            state_next = ST_T7;
            wait_next  = WAIT_LOAD;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_T7: begin
        if (class_reg == C_ST && wait_reg != 3'd0) wait_next = wait_reg - 3'd1;
        else                                       last_step = 1'b1;
      end
      ST_HALT: state_next = ST_HALT;
`ifdef SINGLE_STEP_EN
      ST_STEP_WAIT: begin
        if (Stop)      state_next = ST_HALT;
        else if (Step) state_next = ST_T0;
      end
`endif
      default: state_next = ST_RST;
    endcase
    // Stop is only honoured at the instruction boundary
    if (last_step) begin
`ifdef SINGLE_STEP_EN
      state_next = Stop ? ST_HALT : ST_STEP_WAIT;
`else
      state_next = Stop ? ST_HALT : ST_T0;
`endif
    end
  end

  always_comb begin
    PCout = 1'b0;  PCin = 1'b0;  IncPC = 1'b0;  MARin = 1'b0;
    MDRin = 1'b0;  MDRout = 1'b0;  Read = 1'b0;  RAMin = 1'b0;
    IRin = 1'b0;  Yin = 1'b0;  Cout = 1'b0;  CONin = 1'b0;
    ZLowIn = 1'b0;  ZHighIn = 1'b0;  ZLowout = 1'b0;  ZHighout = 1'b0;
    HIin = 1'b0;  LOin = 1'b0;  HIout = 1'b0;  LOout = 1'b0;
    GRA = 1'b0;  GRB = 1'b0;  GRC = 1'b0;  BAout = 1'b0;
    Rin = 1'b0;  Rout = 1'b0;  InPortOut = 1'b0;  OutPortIn = 1'b0;
    jal_pc_save = 1'b0;
    Run = (state_reg != ST_HALT);
    case (state_reg)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      ST_T1: begin
        ZLowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        // counter still holds its load value only on the first T1 cycle
        PCin = (wait_reg == WAIT_LOAD);
      end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (class_reg)
          C_LD, C_LDI, C_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_ALU, C_ALUI:     begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_MULDIV:          begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_UNARY:           begin GRB = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; end
          C_BR:              begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JR:              begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_JAL:             begin PCout = 1'b1; jal_pc_save = 1'b1; end
          C_IN:              begin InPortOut = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_OUT:             begin GRA = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          C_MFHI:            begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_MFLO:            begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (class_reg)
          C_LD, C_LDI, C_ST, C_ALUI: begin Cout = 1'b1; ZLowIn = 1'b1; end
          C_ALU:    begin GRC = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; end
          C_MULDIV: begin GRB = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; end
          C_UNARY:  begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_BR:     begin PCout = 1'b1; Yin = 1'b1; end
          C_JAL:    begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (class_reg)
          C_LD, C_ST:           begin ZLowout = 1'b1; MARin = 1'b1; end
          C_LDI, C_ALU, C_ALUI: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_MULDIV:             begin ZLowout = 1'b1; LOin = 1'b1; end
          C_BR:                 begin Cout = 1'b1; ZLowIn = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (class_reg)
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          C_BR:     begin ZLowout = 1'b1; PCin = con_reg; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (class_reg)
          C_LD:    begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          C_ST:    begin MDRout = 1'b1; RAMin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // jal writes the return address straight into R15
  for (genvar gi = 0; gi < 16; gi++) begin : g_regin
    assign REGin[gi] = (gi == 15) ? jal_pc_save : 1'b0;
  end

  assign InPortIn  = 1'b0;
  assign state_dbg = state_reg;

endmodule
